// File: rtl/mmio_write_ctrl_pkg.sv
// Shared definitions for the MMIO store-side controller: drain FSM encoding,
// segment address decode constants and the decode helper.
package mmio_write_ctrl_pkg;

    localparam int DECODE_W = 12;

    localparam logic [DECODE_W-1:0] SEG_ADDR_DEFAULT = 12'hF04;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_SEND = 2'd1,
        DRAIN_GAP  = 2'd2
    } drain_state_e;

    // Only the low address bits select the peripheral; upper bits are don't-care.
    function automatic logic addr_hit(
        input logic [DECODE_W-1:0] addr_lo,
        input logic [DECODE_W-1:0] match
    );
        return (addr_lo == match);
    endfunction

endpackage

// File: rtl/mmio_write_ctrl_if.sv
// Valid/ready write channel from the store controller to the display peripheral.
interface mmio_write_ctrl_if;

    logic        seg_valid;
    logic [31:0] seg_data;
    logic        seg_ready;

    modport master (
        output seg_valid,
        output seg_data,
        input  seg_ready
    );

    modport slave (
        input  seg_valid,
        input  seg_data,
        output seg_ready
    );

endinterface

// File: rtl/mmio_write_ctrl_sync_fifo.sv
// Small synchronous FIFO holding queued segment writes. Exposes the head and the
// entry behind it so the drain logic can go back-to-back without a bubble.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [WIDTH-1:0]        head_next,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nx_s;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == {CNT_W{1'b0}});
    assign count       = count_q;
    assign rd_ptr_nx_s = rd_ptr_q + PTR_W'(1);
    assign head        = mem_q[rd_ptr_q];
    assign head_next   = mem_q[rd_ptr_nx_s];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_nx_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: {WIDTH{1'b0}}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_write_ctrl.sv
// Store-side controller: decodes CPU stores into DMEM or the segment queue and
// drains the queue to the display peripheral with an enforced inter-write gap.
module mmio_write_ctrl
    import mmio_write_ctrl_pkg::*;
#(
    parameter int                  DEPTH      = 4,
    parameter logic [DECODE_W-1:0] SEG_ADDR   = SEG_ADDR_DEFAULT,
    parameter int                  GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic                   cpu_we,
    output logic                   stall,
    output logic                   dmem_we,
    output logic [31:0]            dmem_addr,
    output logic [31:0]            dmem_wdata,
    mmio_write_ctrl_if.master      seg,
    output logic [$clog2(DEPTH):0] seg_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam logic [1:0] ST_IDLE = DRAIN_IDLE;
    localparam logic [1:0] ST_SEND = DRAIN_SEND;
    localparam logic [1:0] ST_GAP  = DRAIN_GAP;

    logic             seg_hit_s;
    logic             push_s;
    logic             pop_s;
    logic             handshake_s;
    logic             more_s;
    logic [31:0]      next_data_s;
    logic [31:0]      fifo_head_s;
    logic [31:0]      fifo_head_next_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic             seg_valid_q;
    logic             seg_valid_d;
    logic [31:0]      seg_data_q;
    logic [31:0]      seg_data_d;

    assign seg_hit_s  = addr_hit(cpu_addr[DECODE_W-1:0], SEG_ADDR);
    assign dmem_we    = cpu_we & ~seg_hit_s;
    assign dmem_addr  = cpu_addr;
    assign dmem_wdata = cpu_wdata;

    // Stall is purely a function of the registered count, never of seg_ready.
    assign stall  = cpu_we & seg_hit_s & fifo_full_s;
    assign push_s = cpu_we & seg_hit_s & ~fifo_full_s;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_seg_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .wdata     (cpu_wdata),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .head_next (fifo_head_next_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign seg_count     = fifo_count_s;
    assign seg.seg_valid = seg_valid_q;
    assign seg.seg_data  = seg_data_q;
    assign handshake_s   = seg_valid_q & seg.seg_ready;

    // With one entry left, a same-cycle push becomes the next head via cpu_wdata.
    assign more_s      = (fifo_count_s > CNT_W'(1)) | push_s;
    assign next_data_s = (fifo_count_s > CNT_W'(1)) ? fifo_head_next_s : cpu_wdata;

    // Drain FSM next-state: offer head, pop on handshake, then hold off for the gap.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        seg_valid_d = seg_valid_q;
        seg_data_d  = seg_data_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d     = ST_SEND;
                    seg_valid_d = 1'b1;
                    seg_data_d  = fifo_head_s;
                end else begin
                    seg_valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (handshake_s) begin
                    pop_s = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d     = ST_GAP;
                        gap_cnt_d   = GAP_LOAD;
                        seg_valid_d = 1'b0;
                    end else if (more_s) begin
                        seg_valid_d = 1'b1;
                        seg_data_d  = next_data_s;
                    end else begin
                        state_d     = ST_IDLE;
                        seg_valid_d = 1'b0;
                    end
                end else begin
                    seg_valid_d = 1'b1;
                end
            end
            ST_GAP: begin
                seg_valid_d = 1'b0;
                if (gap_cnt_q == {GAP_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gap_cnt_d   = {GAP_W{1'b0}};
                seg_valid_d = 1'b0;
            end
        endcase
    end

    // Drain FSM and registered peripheral outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= {GAP_W{1'b0}};
            seg_valid_q <= 1'b0;
            seg_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            seg_valid_q <= seg_valid_d;
            seg_data_q  <= seg_data_d;
        end
    end

endmodule

// File: tb/tb_mmio_write_ctrl.sv
// Directed bench for mmio_write_ctrl: one instance with a 1-cycle gap and one
// with no gap share the CPU stimulus and the peripheral ready line.
module tb_mmio_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic        rdy;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;

    logic        stall0, dmem_we0, stall1, dmem_we1;
    logic [31:0] dmem_addr0, dmem_wdata0, dmem_addr1, dmem_wdata1;
    logic [2:0]  cnt0, cnt1;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] got_q [$];

    always #5 clk = ~clk;

    mmio_write_ctrl_if seg0_if ();
    mmio_write_ctrl_if seg1_if ();

    assign seg0_if.seg_ready = rdy;
    assign seg1_if.seg_ready = rdy;

    mmio_write_ctrl #(.DEPTH(4), .SEG_ADDR(12'hF04), .GAP_CYCLES(1)) u_dut_g1 (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .stall      (stall0),
        .dmem_we    (dmem_we0),
        .dmem_addr  (dmem_addr0),
        .dmem_wdata (dmem_wdata0),
        .seg        (seg0_if.master),
        .seg_count  (cnt0)
    );

    mmio_write_ctrl #(.DEPTH(4), .SEG_ADDR(12'hF04), .GAP_CYCLES(0)) u_dut_g0 (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .stall      (stall1),
        .dmem_we    (dmem_we1),
        .dmem_addr  (dmem_addr1),
        .dmem_wdata (dmem_wdata1),
        .seg        (seg1_if.master),
        .seg_count  (cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg_store(input logic [31:0] data);
        cpu_addr  = 32'h0000_0F04;
        cpu_wdata = data;
        cpu_we    = 1'b1;
    endtask

    task automatic bus_idle();
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0000;
        cpu_wdata = 32'h0000_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Record every write accepted by the gap=1 instance over a bounded window.
    task automatic collect0(input int n_cycles);
        got_q.delete();
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            if (seg0_if.seg_valid && rdy) got_q.push_back(seg0_if.seg_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        bus_idle();
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_valid", 32'(seg0_if.seg_valid), 32'd0);
        check_eq("rst_data",  seg0_if.seg_data, 32'h0000_0000);
        check_eq("rst_count", 32'(cnt0), 32'd0);
        check_eq("rst_stall", 32'(stall0), 32'd0);
        rst = 1'b0;
        tick();

        // DMEM store passes straight through
        cpu_addr  = 32'h0000_0010;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_we    = 1'b1;
        @(negedge clk);
        check_eq("dm_we",     32'(dmem_we0), 32'd1);
        check_eq("dm_addr",   dmem_addr0, 32'h0000_0010);
        check_eq("dm_wdata",  dmem_wdata0, 32'hDEAD_BEEF);
        check_eq("dm_stall",  32'(stall0), 32'd0);
        check_eq("dm_we_g0",  32'(dmem_we1), 32'd1);
        check_eq("dm_addr_g0", dmem_addr1, 32'h0000_0010);
        check_eq("dm_data_g0", dmem_wdata1, 32'hDEAD_BEEF);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("dm_count", 32'(cnt0), 32'd0);
        check_eq("dm_valid", 32'(seg0_if.seg_valid), 32'd0);

        // Single segment store, gap of 1
        tick();
        rdy = 1'b1;
        seg_store(32'h1234_5678);
        @(negedge clk);
        check_eq("s1_dmem_we", 32'(dmem_we0), 32'd0);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("s1_count1", 32'(cnt0), 32'd1);
        check_eq("s1_valid_k", 32'(seg0_if.seg_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("s1_valid",   32'(seg0_if.seg_valid), 32'd1);
        check_eq("s1_data",    seg0_if.seg_data, 32'h1234_5678);
        tick();
        @(negedge clk);
        check_eq("s1_gap1",    32'(seg0_if.seg_valid), 32'd0);
        check_eq("s1_popped",  32'(cnt0), 32'd0);
        tick();
        @(negedge clk);
        check_eq("s1_gap2",    32'(seg0_if.seg_valid), 32'd0);

        // Fill with ready low, stall on the fifth store
        tick();
        do_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            seg_store(32'(i));
            @(negedge clk);
            if (i < 5) check_eq($sformatf("fill_nostall%0d", i), 32'(stall0), 32'd0);
            else       check_eq("fill_stall5", 32'(stall0), 32'd1);
            tick();
        end
        @(negedge clk);
        check_eq("full_stall",   32'(stall0), 32'd1);
        check_eq("full_stall_g0", 32'(stall1), 32'd1);
        check_eq("full_count",   32'(cnt0), 32'd4);
        check_eq("full_valid",   32'(seg0_if.seg_valid), 32'd1);
        check_eq("full_head",    seg0_if.seg_data, 32'd1);
        tick();
        rdy = 1'b1;
        @(negedge clk);
        check_eq("rdy_stall",    32'(stall0), 32'd1);
        tick();
        @(negedge clk);
        check_eq("pop_unstall",  32'(stall0), 32'd0);
        check_eq("pop_count",    32'(cnt0), 32'd3);
        check_eq("pop_gap",      32'(seg0_if.seg_valid), 32'd0);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("push5_count",  32'(cnt0), 32'd4);
        collect0(20);
        check_eq("drain_n", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size() && i < 4; i++)
            check_eq($sformatf("drain%0d", i + 2), got_q[i], 32'(i + 2));
        check_eq("drain_empty", 32'(cnt0), 32'd0);

        // Gap of 0, back-to-back
        tick();
        do_reset();
        rdy = 1'b1;
        seg_store(32'd1);
        tick();
        seg_store(32'd2);
        @(negedge clk);
        check_eq("b2b_v0", 32'(seg1_if.seg_valid), 32'd0);
        tick();
        seg_store(32'd3);
        @(negedge clk);
        check_eq("b2b_v1", 32'(seg1_if.seg_valid), 32'd1);
        check_eq("b2b_d1", seg1_if.seg_data, 32'd1);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("b2b_v2", 32'(seg1_if.seg_valid), 32'd1);
        check_eq("b2b_d2", seg1_if.seg_data, 32'd2);
        tick();
        @(negedge clk);
        check_eq("b2b_v3", 32'(seg1_if.seg_valid), 32'd1);
        check_eq("b2b_d3", seg1_if.seg_data, 32'd3);
        tick();
        @(negedge clk);
        check_eq("b2b_v4",  32'(seg1_if.seg_valid), 32'd0);
        check_eq("b2b_cnt", 32'(cnt1), 32'd0);

        // Push and pop on the same edge at count 3
        tick();
        do_reset();
        rdy = 1'b0;
        seg_store(32'h0000_00A1);
        tick();
        seg_store(32'h0000_00B2);
        tick();
        seg_store(32'h0000_00C3);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("pp_cnt_pre", 32'(cnt0), 32'd3);
        check_eq("pp_head",    seg0_if.seg_data, 32'h0000_00A1);
        seg_store(32'h0000_00D4);
        rdy = 1'b1;
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("pp_cnt", 32'(cnt0), 32'd3);
        collect0(15);
        check_eq("pp_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check_eq("pp_o0", got_q[0], 32'h0000_00B2);
            check_eq("pp_o1", got_q[1], 32'h0000_00C3);
            check_eq("pp_o2", got_q[2], 32'h0000_00D4);
        end

        // Reset in the middle of a transfer
        tick();
        do_reset();
        rdy = 1'b0;
        seg_store(32'h0000_0111);
        tick();
        seg_store(32'h0000_0222);
        tick();
        seg_store(32'h0000_0333);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("mr_valid_pre", 32'(seg0_if.seg_valid), 32'd1);
        check_eq("mr_cnt_pre",   32'(cnt0), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr_valid", 32'(seg0_if.seg_valid), 32'd0);
        check_eq("mr_count", 32'(cnt0), 32'd0);
        check_eq("mr_data",  seg0_if.seg_data, 32'h0000_0000);
        seg_store(32'h0000_ABCD);
        rdy = 1'b1;
        #1;
        check_eq("mr_stall", 32'(stall0), 32'd0);
        tick();
        bus_idle();
        @(negedge clk);
        check_eq("mr_cnt1", 32'(cnt0), 32'd1);
        collect0(10);
        check_eq("mr_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check_eq("mr_fresh", got_q[0], 32'h0000_ABCD);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_write_ctrl.md
# mmio_write_ctrl

Store-side controller between the pipeline MEM stage and the memory-mapped write targets. Decodes each CPU store, passes DMEM stores straight through, and queues seven-segment stores in a small FIFO. The FIFO drains to the display peripheral over a valid/ready handshake with a programmable inter-write gap. The pipeline is stalled only when a segment store finds the FIFO full.

## Interface
- `DEPTH`, 4: segment FIFO entries; power of two, at least 2.
- `SEG_ADDR`, 12'hF04: `cpu_addr[11:0]` value that selects the segment peripheral.
- `GAP_CYCLES`, 1: idle cycles forced after each accepted segment write; 0 allowed.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `cpu_addr` in 32: store address from the MEM stage.
- `cpu_wdata` in 32: store data.
- `cpu_we` in 1: store strobe, one cycle per store unless `stall` is high.
- `stall` out 1: combinational. While high, the CPU holds `cpu_addr`, `cpu_wdata` and `cpu_we`.
- `dmem_we` out 1: DMEM write enable. Combinational.
- `dmem_addr` out 32: equals `cpu_addr`.
- `dmem_wdata` out 32: equals `cpu_wdata`.
- `seg_valid` out 1: registered. A segment write is offered.
- `seg_data` out 32: registered. Holds the FIFO head.
- `seg_ready` in 1: the peripheral accepts the offered write.
- `seg_count` out clog2(DEPTH)+1: FIFO occupancy. Registered.

## Operation
- Decode:
  - `seg_hit = (cpu_addr[11:0] == SEG_ADDR)`.
  - `dmem_we = cpu_we & ~seg_hit`.
  - `stall = cpu_we & seg_hit & full`, where `full = (seg_count == DEPTH)`.
  - DMEM stores never stall and never enter the FIFO.
- Push: `cpu_we & seg_hit & ~full` writes `cpu_wdata` at the write pointer.
  - While stalled, nothing is pushed.
  - A full FIFO does not accept a push in the same cycle as a pop. `stall` does not depend on `seg_ready`.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- `seg_count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Drain FSM:
  - IDLE:
    - `seg_valid` = 0.
    - If `seg_count` != 0, load `seg_data` from the head and go to SEND.
  - SEND:
    - `seg_valid` = 1.
    - `seg_data` holds the head value and stays stable until the handshake.
    - On `seg_valid & seg_ready`: pop.
      - If `GAP_CYCLES` > 0, go to GAP and load the gap counter with `GAP_CYCLES`-1.
      - If `GAP_CYCLES` = 0 and entries remain after the pop, stay in SEND with the new head. `seg_valid` stays high (back-to-back).
      - Otherwise go to IDLE.
  - GAP:
    - `seg_valid` = 0.
    - Counter decrements each cycle. At 0, go to IDLE.
- Ordering: segment writes leave in CPU program order. DMEM writes have no ordering guarantee relative to queued segment writes.
- Reset (including mid-transfer):
  - FSM to IDLE, pointers to 0, gap counter to 0.
  - `seg_count`=0, `seg_valid`=0, `seg_data`=0.
  - Queued entries are discarded. `stall` falls once `seg_count`=0.

## Timing
- Push at edge k makes `seg_count`=1 after k. FSM enters SEND at edge k+1, so `seg_valid` is high in cycle k+1.
- Minimum store-to-peripheral latency is 2 cycles.
- Handshake at edge m (SEND): pop at m.
  - With `GAP_CYCLES`=G ≥ 1, `seg_valid` is low for G+1 cycles (G GAP cycles plus one IDLE).
  - The next offer starts no earlier than cycle m+G+2.
- Sustained segment throughput:
  - 1 write per cycle with G=0 and `seg_ready` tied high.
  - Otherwise 1 write per G+2 cycles.
- `stall` reaches the pipeline the same cycle as `full`. No registered stall path.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, SEND, GAP);
  - the `SEG_ADDR` default;
  - the address-decode width constant (12).
- Sub-module `sync_fifo` (parameters WIDTH=32, DEPTH) provides:
  - storage, pointers and the count;
  - the `full` and `empty` flags.
- The top level holds the decode, the stall logic and the drain FSM.

## Test plan
- DMEM store to 0x0000_0010, data 0xDEAD_BEEF:
  - `dmem_we`=1 that cycle with address and data passed through.
  - `seg_count` stays 0 and `stall`=0.
- Segment store to 0x0000_0F04, data 0x1234_5678, `seg_ready` high, G=1:
  - `seg_valid` high 2 cycles after `cpu_we`, with `seg_data`=0x1234_5678.
  - Pop on the next edge, then `seg_valid` low for 2 cycles.
- `seg_ready` low, 5 consecutive segment stores (data 1..5):
  - `seg_count` reaches 4.
  - The 5th store holds `stall`=1 until `seg_ready` rises. Stall drops the cycle after the first pop.
  - The drained sequence is 1, 2, 3, 4, 5.
- G=0, `seg_ready` high, 3 segment stores:
  - After the first offer, `seg_valid` stays high 3 consecutive cycles.
  - `seg_data` is 1, 2, 3.
- `seg_count`=3 with a push and a pop on the same edge: `seg_count` stays 3 and the FIFO order is preserved.
- `rst` asserted during SEND with 3 entries queued:
  - Next cycle `seg_valid`=0, `seg_count`=0 and `stall`=0.
  - No stale entry appears after a fresh segment store.
